// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline registers of the 5-stage core:
// the ID/EX control bundle layout and instruction register-index positions.
package pipe_pkg;

    localparam int CTRL_W = 19;

    // Bit offsets of each field inside the packed control bundle (LSB = func3).
    localparam int FUNC3_LSB     = 0;
    localparam int FUNC3_W       = 3;
    localparam int OPCODE_LSB    = 3;
    localparam int OPCODE_W      = 7;
    localparam int RESULTSRC_BIT = 10;
    localparam int ALUCTRL_LSB   = 11;
    localparam int ALUCTRL_W     = 4;
    localparam int REGWRITE_BIT  = 15;
    localparam int ALUSRC_BIT    = 16;
    localparam int MEMWRITE_BIT  = 17;
    localparam int PCSRC_BIT     = 18;

    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 7;

    typedef struct packed {
        logic       pc_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_control;
        logic       result_src;
        logic [6:0] opcode;
        logic [2:0] func3;
    } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry elastic pipeline register (main + optional skid) with
// valid/ready handshake and flush; reused for ID/EX, EX/MEM and MEM/WB.
module pipe_skid_reg #(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         main_load;

    assign accept    = in_valid & in_ready;
    assign main_load = !main_valid | out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main refills from skid first so ordering is preserved; flush only drops valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (main_load) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic         skid_q;
            logic [W-1:0] skid_d;

            // in_ready comes straight from this flop, so skid can't be written while valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= 1'b0;
                    skid_d <= '0;
                end else if (flush) begin
                    skid_q <= 1'b0;
                end else if (skid_q) begin
                    if (main_load) begin
                        skid_q <= 1'b0;
                    end
                end else if (accept && !main_load) begin
                    skid_q <= 1'b1;
                    skid_d <= in_data;
                end
            end

            assign skid_valid = skid_q;
            assign skid_data  = skid_d;
            assign in_ready   = !skid_q;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign in_ready   = main_load;
        end
    endgenerate

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage: packs the decode payload, register indices and control
// bundle into one elastic register and unpacks it for EX and forwarding.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 19,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pcD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   Port_A,
    input  logic [XLEN-1:0]   Port_B,
    input  logic [XLEN-1:0]   immextD,
    input  logic [31:0]       instructionD,
    input  logic [CTRL_W-1:0] ctrlD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pcE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [CTRL_W-1:0] ctrlE
);

    import pipe_pkg::REG_IDX_W;
    import pipe_pkg::RS1_LSB;
    import pipe_pkg::RS2_LSB;
    import pipe_pkg::RD_LSB;

    localparam int W = 5 * XLEN + 3 * REG_IDX_W + CTRL_W;

    logic [W-1:0]      in_data;
    logic [W-1:0]      out_data;
    logic [CTRL_W-1:0] ctrl_held;
    logic              unused_instr_bits;

    assign in_data = {pcD, PCPlus4D, Port_A, Port_B, immextD,
                      instructionD[RS1_LSB +: REG_IDX_W],
                      instructionD[RS2_LSB +: REG_IDX_W],
                      instructionD[RD_LSB +: REG_IDX_W],
                      ctrlD};

    // Only the register-index fields of the raw instruction travel to EX.
    assign unused_instr_bits = ^{instructionD[31:25], instructionD[14:12], instructionD[6:0]};

    pipe_skid_reg #(
        .W    (W),
        .SKID (SKID)
    ) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {pcE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, ctrl_held} = out_data;

    // Stale payload after a flush is harmless as long as no control bit escapes.
    assign ctrlE = out_valid ? ctrl_held : '0;

endmodule
